// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet generator feeding one mesh input port.
// Each run sends num_pkts packets of pkt_len flits. Destinations rotate
// through the set bits of dest_mask. Each flit carries its flit index, the
// packet sequence number and SRC_ID in tdata.
// Optional feature: define AXIS_TRAFFIC_GEN_STALL_CNT_EN to add the
// stall_cycles output, which counts backpressure cycles.
module axis_traffic_gen #(
    parameter int TDEST_WIDTH = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int SRC_ID      = 0,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        pkt_len,
    input  logic [LEN_WIDTH-1:0]        num_pkts,
    input  logic [2**TDEST_WIDTH-1:0]   dest_mask,
    output logic                        axis_out_tvalid,
    input  logic                        axis_out_tready,
    output logic [TDATA_WIDTH-1:0]      axis_out_tdata,
    output logic                        axis_out_tlast,
    output logic [TDEST_WIDTH-1:0]      axis_out_tdest,
    output logic                        busy,
    output logic                        done,
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
    output logic [31:0]                 stall_cycles,
`endif
    output logic [LEN_WIDTH-1:0]        pkts_sent
);

    localparam int unsigned NDEST = 2**TDEST_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]             state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   num_q;
    logic [NDEST-1:0]       mask_q;
    logic [LEN_WIDTH-1:0]   flit_idx;
    logic [TDEST_WIDTH-1:0] dest_q;
    logic [TDEST_WIDTH-1:0] first_dest;
    logic [TDEST_WIDTH-1:0] next_dest;
    logic [TDEST_WIDTH-1:0] cand;
    logic                   found;
    logic                   xfer;
    logic                   last_flit;
    logic                   last_pkt;
    logic                   empty_run;

    assign xfer      = (state == SEND) && axis_out_tready;
    assign last_flit = (flit_idx == len_q - LEN_WIDTH'(1));
    assign last_pkt  = (pkts_sent == num_q - LEN_WIDTH'(1));
    assign empty_run = (pkt_len == '0) || (num_pkts == '0) || (dest_mask == '0);

    // Lowest set bit of the incoming mask; scanning downward leaves the lowest hit.
    always_comb begin
        first_dest = '0;
        for (int unsigned k = 0; k < NDEST; k++) begin
            if (dest_mask[TDEST_WIDTH'(NDEST - 1 - k)])
                first_dest = TDEST_WIDTH'(NDEST - 1 - k);
        end
    end

    // Next set bit above the current destination. The TDEST_WIDTH-bit add wraps naturally.
    always_comb begin
        next_dest = dest_q;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NDEST; k++) begin
            cand = dest_q + TDEST_WIDTH'(k);
            if (!found && mask_q[cand]) begin
                next_dest = cand;
                found     = 1'b1;
            end
        end
    end

    // Run control: capture config, walk flits and packets, then finish.
    // pkts_sent also serves as the packet sequence number carried in tdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            num_q     <= '0;
            mask_q    <= '0;
            flit_idx  <= '0;
            dest_q    <= '0;
            pkts_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= pkt_len;
                        num_q     <= num_pkts;
                        mask_q    <= dest_mask;
                        flit_idx  <= '0;
                        pkts_sent <= '0;
                        dest_q    <= first_dest;
                        state     <= empty_run ? FINISH : SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last_flit) begin
                            flit_idx  <= '0;
                            pkts_sent <= pkts_sent + LEN_WIDTH'(1);
                            dest_q    <= next_dest;
                            if (last_pkt)
                                state <= FINISH;
                        end else begin
                            flit_idx <= flit_idx + LEN_WIDTH'(1);
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign axis_out_tvalid = (state == SEND);
    assign axis_out_tlast  = axis_out_tvalid && last_flit;
    assign axis_out_tdest  = axis_out_tvalid ? dest_q : '0;
    assign busy            = (state != IDLE);
    assign done            = (state == FINISH);

    // Flit payload: index, sequence and source ID. The payload is zero while idle.
    always_comb begin
        axis_out_tdata = '0;
        if (axis_out_tvalid) begin
            axis_out_tdata[15:0]              = 16'(flit_idx);
            axis_out_tdata[31:16]             = 16'(pkts_sent);
            axis_out_tdata[32 +: TDEST_WIDTH] = TDEST_WIDTH'(SRC_ID);
        end
    end

`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
    // Saturating count of cycles where a flit was offered but not accepted.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (state == IDLE && start)
            stall_cycles <= '0;
        else if (axis_out_tvalid && !axis_out_tready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Self-checking bench for axis_traffic_gen with a queue-based reference model.
module tb_axis_traffic_gen;

    localparam int SRC = 5;

    logic        clk = 1'b0;
    logic        rst, start, tready;
    logic [7:0]  pkt_len, num_pkts;
    logic [15:0] dest_mask;
    logic        tvalid, tlast, busy, done;
    logic [63:0] tdata;
    logic [3:0]  tdest;
    logic [7:0]  pkts_sent;
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    axis_traffic_gen #(.TDEST_WIDTH(4), .TDATA_WIDTH(64), .SRC_ID(SRC), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .num_pkts(num_pkts),
        .dest_mask(dest_mask), .axis_out_tvalid(tvalid), .axis_out_tready(tready),
        .axis_out_tdata(tdata), .axis_out_tlast(tlast), .axis_out_tdest(tdest),
        .busy(busy), .done(done),
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .pkts_sent(pkts_sent));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  dest;
        logic        last;
        int          cyc;
    } flit_t;

    flit_t exp_q[$];
    flit_t obs_q[$];
    int    tests = 0, fails = 0;
    int    done_cyc, done_cnt, stall_obs, unstable;
    bit    timeout;
    logic  busy_after;

    // Expected flit stream: destinations cycle through the set bits in ascending order.
    function automatic void model_run(input int len, input int num, input logic [15:0] mask);
        int bits[$];
        flit_t e;
        exp_q.delete();
        if (len == 0 || num == 0 || mask == 0) return;
        for (int b = 0; b < 16; b++) if (mask[b]) bits.push_back(b);
        for (int p = 0; p < num; p++)
            for (int f = 0; f < len; f++) begin
                e.data = '0;
                e.data[15:0]  = 16'(f);
                e.data[31:16] = 16'(p);
                e.data[35:32] = 4'(SRC);
                e.dest = 4'(bits[p % bits.size()]);
                e.last = (f == len - 1);
                e.cyc  = 0;
                exp_q.push_back(e);
            end
    endfunction

    // Issue a start at the current negedge; returns at the negedge after acceptance.
    task automatic go(input int len, input int num, input logic [15:0] mask);
        pkt_len = 8'(len); num_pkts = 8'(num); dest_mask = mask; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drive tready (0: always, 1: toggle, 2: random) and record handshakes until done.
    task automatic capture(input int mode, input int inj_cyc, input int budget);
        flit_t f, h;
        bit held = 0;
        obs_q.delete();
        done_cyc = -1; done_cnt = 0; stall_obs = 0; unstable = 0; timeout = 1; busy_after = 1'bx;
        for (int c = 0; c < budget; c++) begin
            case (mode)
                0: tready = 1'b1;
                1: tready = (c % 2 == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            start = (c == inj_cyc);
            if (c == inj_cyc) begin pkt_len = 8'd5; num_pkts = 8'd4; dest_mask = 16'hffff; end
            if (held && (!tvalid || tdata !== h.data || tdest !== h.dest || tlast !== h.last))
                unstable++;
            held = 0;
            if (tvalid) begin
                f.data = tdata; f.dest = tdest; f.last = tlast; f.cyc = c;
                if (tready) obs_q.push_back(f);
                else begin stall_obs++; held = 1; h = f; end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
                if (tvalid) unstable++;
            end
            if (done_cyc >= 0 && c > done_cyc) begin
                busy_after = busy; timeout = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; tready = 1'b0; pkt_len = '0; num_pkts = '0; dest_mask = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({tvalid, tlast, busy, done} !== 4'b0 || tdata !== '0 || tdest !== '0 || pkts_sent !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v%b l%b b%b d%b data%h dest%h ps%0d want all zero",
                     tvalid, tlast, busy, done, tdata, tdest, pkts_sent);
        end
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
        tests++;
        if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_flit;
        model_run(1, 3, 16'b1110);
        go(1, 3, 16'b1110);
        capture(0, -1, 50);
        tests++; if (timeout) begin fails++; $display("FAIL single_timeout: got timeout want done"); end
        tests++; if (obs_q.size() != 3) begin fails++; $display("FAIL single_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            tests++;
            if (obs_q[i].dest !== 4'(i + 1) || obs_q[i].last !== 1'b1 || obs_q[i].data !== exp_q[i].data
                || obs_q[i].cyc != i) begin
                fails++;
                $display("FAIL single_flit%0d: got dest%0d last%b data%h cyc%0d want dest%0d last1 data%h cyc%0d",
                         i, obs_q[i].dest, obs_q[i].last, obs_q[i].data, obs_q[i].cyc, i + 1, exp_q[i].data, i);
            end
        end
        tests++;
        if (done_cyc != 3 || done_cnt != 1 || busy_after !== 1'b0 || pkts_sent !== 8'd3) begin
            fails++;
            $display("FAIL single_done: got cyc%0d cnt%0d busy%b ps%0d want cyc3 cnt1 busy0 ps3",
                     done_cyc, done_cnt, busy_after, pkts_sent);
        end
    endtask

    task automatic test_multi_flit;
        model_run(4, 2, 16'b0001);
        go(4, 2, 16'b0001);
        capture(0, -1, 50);
        tests++; if (timeout || obs_q.size() != 8) begin fails++; $display("FAIL multi_count: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].data[15:0] !== 16'(i % 4)
                || obs_q[i].data[31:16] !== 16'(i / 4) || obs_q[i].dest !== 4'd0
                || obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != i) begin
                fails++;
                $display("FAIL multi_flit%0d: got data%h dest%0d last%b cyc%0d want data%h dest0 last%b cyc%0d",
                         i, obs_q[i].data, obs_q[i].dest, obs_q[i].last, obs_q[i].cyc, exp_q[i].data, exp_q[i].last, i);
            end
        end
        tests++;
        if (done_cyc != 8 || done_cnt != 1 || pkts_sent !== 8'd2) begin
            fails++; $display("FAIL multi_done: got cyc%0d cnt%0d ps%0d want cyc8 cnt1 ps2", done_cyc, done_cnt, pkts_sent);
        end
    endtask

    task automatic test_stall;
        model_run(3, 1, 16'b0100);
        go(3, 1, 16'b0100);
        capture(1, -1, 50);
        tests++; if (timeout || obs_q.size() != 3) begin fails++; $display("FAIL stall_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].dest !== exp_q[i].dest
                || obs_q[i].last !== exp_q[i].last || obs_q[i].cyc != 2 * i) begin
                fails++;
                $display("FAIL stall_flit%0d: got data%h dest%0d cyc%0d want data%h dest%0d cyc%0d",
                         i, obs_q[i].data, obs_q[i].dest, obs_q[i].cyc, exp_q[i].data, exp_q[i].dest, 2 * i);
            end
        end
        tests++;
        if (unstable != 0 || stall_obs != 2 || done_cyc != 5 || done_cnt != 1) begin
            fails++;
            $display("FAIL stall_hold: got unstable%0d stalls%0d done_cyc%0d cnt%0d want 0 2 5 1",
                     unstable, stall_obs, done_cyc, done_cnt);
        end
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
        tests++;
        if (stall_cycles !== 32'd2) begin fails++; $display("FAIL stall_counter: got %0d want 2", stall_cycles); end
`endif
    endtask

    task automatic test_empty;
        int lens[3]  = '{2, 0, 2};
        int nums[3]  = '{2, 2, 0};
        int masks[3] = '{0, 3, 3};
        for (int k = 0; k < 3; k++) begin
            go(lens[k], nums[k], 16'(masks[k]));
            capture(0, -1, 10);
            tests++;
            if (timeout || obs_q.size() != 0 || done_cyc != 0 || done_cnt != 1
                || pkts_sent !== 8'd0 || busy_after !== 1'b0) begin
                fails++;
                $display("FAIL empty%0d: got flits%0d done_cyc%0d cnt%0d ps%0d busy%b want 0 0 1 0 0",
                         k, obs_q.size(), done_cyc, done_cnt, pkts_sent, busy_after);
            end
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        go(2, 3, 16'h0011);
        tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        tests++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkts_sent !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid: got v%b b%b d%b ps%0d want 0 0 0 0", tvalid, busy, done, pkts_sent);
        end
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (done || tvalid || busy) bad++;
            @(negedge clk);
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL reset_quiet: got %0d active cycles want 0", bad); end
        model_run(2, 3, 16'h0011);
        go(2, 3, 16'h0011);
        capture(0, -1, 50);
        tests++; if (timeout || obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rerun_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].dest !== exp_q[i].dest || obs_q[i].last !== exp_q[i].last) begin
                fails++;
                $display("FAIL rerun_flit%0d: got data%h dest%0d want data%h dest%0d", i, obs_q[i].data, obs_q[i].dest, exp_q[i].data, exp_q[i].dest);
            end
        end
        tests++; if (done_cnt != 1 || pkts_sent !== 8'd3) begin fails++; $display("FAIL rerun_done: got cnt%0d ps%0d want 1 3", done_cnt, pkts_sent); end
    endtask

    task automatic test_restart_ignored;
        model_run(3, 2, 16'b0110);
        go(3, 2, 16'b0110);
        capture(0, 2, 50);
        tests++; if (timeout || obs_q.size() != 6) begin fails++; $display("FAIL restart_count: got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            tests++;
            if (obs_q[i].data !== exp_q[i].data || obs_q[i].dest !== exp_q[i].dest || obs_q[i].last !== exp_q[i].last) begin
                fails++;
                $display("FAIL restart_flit%0d: got data%h dest%0d last%b want data%h dest%0d last%b",
                         i, obs_q[i].data, obs_q[i].dest, obs_q[i].last, exp_q[i].data, exp_q[i].dest, exp_q[i].last);
            end
        end
        tests++;
        if (done_cyc != 6 || done_cnt != 1 || pkts_sent !== 8'd2) begin
            fails++; $display("FAIL restart_done: got cyc%0d cnt%0d ps%0d want 6 1 2", done_cyc, done_cnt, pkts_sent);
        end
    endtask

    task automatic test_random;
        int len, num, err;
        logic [15:0] mask;
        for (int r = 0; r < 6; r++) begin
            len  = $urandom_range(1, 5);
            num  = $urandom_range(1, 4);
            mask = 16'($urandom_range(1, 65535));
            model_run(len, num, mask);
            go(len, num, mask);
            capture(2, -1, 400);
            err = 0;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
                if (obs_q[i].data !== exp_q[i].data || obs_q[i].dest !== exp_q[i].dest || obs_q[i].last !== exp_q[i].last)
                    err++;
            tests++;
            if (timeout || obs_q.size() != exp_q.size() || err != 0 || unstable != 0 || done_cnt != 1
                || done_cyc != obs_q[obs_q.size() - 1].cyc + 1 || pkts_sent !== 8'(num)) begin
                fails++;
                $display("FAIL random%0d: got flits%0d bad%0d unstable%0d done%0d ps%0d want flits%0d bad0 unstable0 done1 ps%0d",
                         r, obs_q.size(), err, unstable, done_cnt, pkts_sent, exp_q.size(), num);
            end
`ifdef AXIS_TRAFFIC_GEN_STALL_CNT_EN
            tests++;
            if (stall_cycles !== 32'(stall_obs)) begin
                fails++; $display("FAIL random_stall%0d: got %0d want %0d", r, stall_cycles, stall_obs);
            end
`endif
        end
    endtask

    initial begin
        test_reset;
        test_single_flit;
        test_multi_flit;
        test_stall;
        test_empty;
        test_reset_mid;
        test_restart_ignored;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
